seven_seg_mux_n: RTL
====================

// Module: seven_seg_mux_n
// PURPOSE
//  Parametrised N-digit time-multiplexed seven-segment driver; successor to the fixed 4-digit hex driver.
//  Adds per-digit decimal points, per-digit blanking, PWM brightness and tear-free frame-synchronous value loading.
//  Sits between lab datapaths and the board's common-anode display (active-low cathodes and anodes).
// PARAMETERS
//  NUM_DIGITS  4   number of digits/anodes driven (2..8)
//  DIV_W       11  slot length = 2**DIV_W clk cycles per digit (refresh prescaler width)
//  BRIGHT_W    3   brightness code width; must be <= DIV_W
// PORTS
//  clk         in   1              system clock, all logic on posedge
//  reset       in   1              synchronous, active-high reset
//  values      in   4*NUM_DIGITS   hex nibbles; digit i = values[4i+3:4i], digit 0 = rightmost
//  dp_in       in   NUM_DIGITS     decimal-point request per digit (1 = lit)
//  blank       in   NUM_DIGITS     force digit dark (1 = blank)
//  load        in   1              request to capture values/dp_in/blank into shadow regs
//  brightness  in   BRIGHT_W       duty code; all-ones = 100% on
//  sv_disp     out  7              cathodes g..a, active-low
//  sv_dp       out  1              decimal-point cathode, active-low
//  sv_anode    out  NUM_DIGITS     anodes, active-low, one-hot-low when lit
//  frame_done  out  1              1-cycle pulse when shadow regs are updated
// BEHAVIOUR
//  Reset (reset=1 at posedge): slot_cnt=0, digit idx=0, pending=0, shadow values/dp=0, shadow blank=all-ones;
//   sv_anode=all-ones, sv_disp=7'h7F, sv_dp=1, frame_done=0. Reset mid-frame discards a pending load.
//  Prescaler: slot_cnt (DIV_W bits) increments every cycle, wraps 2**DIV_W-1 -> 0; on wrap idx advances,
//   idx NUM_DIGITS-1 -> 0 (frame wrap).
//  Load handshake: load=1 sets pending and latches inputs into staging regs; a later load before the
//   frame wrap overwrites the staging regs (last wins). Shadow regs update on the frame-wrap cycle if pending or
//   load is asserted that cycle (load-cycle data wins); pending clears and frame_done pulses that same cycle.
//   Shadow never changes mid-frame -> no tearing.
//  Duty: digit lit when slot_cnt[DIV_W-1 -: BRIGHT_W] <= brightness; brightness sampled every cycle.
//   brightness=0 -> 1/2**BRIGHT_W duty; all-ones -> always on.
//  Output stage registered: sv_anode/sv_disp/sv_dp reflect idx, slot_cnt of the previous cycle (latency 1).
//  Dark digit (blanked, suppressed, or outside duty): sv_anode all-ones AND sv_disp=7'h7F, sv_dp=1.
//  Lit digit: sv_anode bit idx=0, others 1; sv_disp=font[nibble]; sv_dp=~dp.
//  Font (g..a, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//  No combinational path from any input to any output.
// CONFIGURATION
//  SEVSEG_LZ_BLANK_EN defined: leading-zero suppression on shadow values; digit i (i>0) dark when it and
//   every higher digit hold 0; digit 0 never suppressed; a set dp on a digit stops suppression at and below it.
//  Undefined: zeros always displayed; only blank[] darkens digits. Port list identical in both builds.
// STRUCTURE
//  Package sevseg_pkg: SEG_BLANK=7'h7F, 16-entry font table constant, ANODE_OFF function of width.
//  Sub-module sevseg_hex_decoder: combinational nibble -> 7-bit active-low segment pattern from the package table.
//  Top holds prescaler, idx counter, staging/shadow regs, LZ logic, duty compare and output registers.
// TESTING (NUM_DIGITS=4, DIV_W=4, BRIGHT_W=2)
//  1 reset held 3 cycles -> sv_anode=4'b1111, sv_disp=7'h7F, sv_dp=1, frame_done=0; blank shadow all-ones.
//  2 load values=16'h12AF, brightness=3, blank=0 -> after frame wrap, frame_done pulses once; each 16-cycle
//    slot shows anode 1110/1101/1011/0111 with disp 0E/08/24/79 in order.
//  3 brightness=0 -> each digit lit 4 of 16 cycles (slot_cnt 0..3), dark 12; brightness=1 -> 8 of 16.
//  4 load 16'h1111 mid-frame then 16'h2222 before wrap -> no change until wrap, then 16'h2222 shown, one frame_done.
//  5 dp_in=4'b0100, blank=4'b0001 loaded -> digit 2 sv_dp=0, digit 0 fully dark, other digits sv_dp=1.
//  6 SEVSEG_LZ_BLANK_EN, values=16'h0050 -> digits 3,2 dark, digits 1,0 show 5,0; values=0 -> only digit 0 shows 0.
//  7 reset asserted with pending load mid-frame -> outputs return to reset values; old data never displayed.

Source files
------------

// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_pkg
//  Description : Shared constants for the multiplexed seven-segment driver:
//                blank segment pattern, hex font table (g..a, active-low)
//                and an anode-off mask helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sevseg_pkg;

    // All cathodes released (segments dark on a common-anode display).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex font, index = nibble value, pattern = {g,f,e,d,c,b,a} active-low.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Anode mask with the low 'width' bits set (all digits off, active-low).
    function automatic logic [7:0] ANODE_OFF(input int width);
        logic [7:0] v_mask;
        v_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < width) begin
                v_mask[i] = 1'b1;
            end
        end
        return v_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_hex_decoder
//  Description : Combinational nibble to seven-segment pattern (g..a,
//                active-low) using the shared font table.
//  Revision    : 1.0  initial release
// ============================================================================
module sevseg_hex_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Straight table lookup; the table already holds active-low patterns.
    always_comb begin
        o_seg = SEG_FONT[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_mux_n
//  Description : N-digit time-multiplexed seven-segment driver for a
//                common-anode display. Per-digit decimal points and blanking,
//                PWM brightness, and frame-synchronous (tear-free) loading of
//                displayed values through staging and shadow registers.
//                Optional build macro SEVSEG_LZ_BLANK_EN enables leading-zero
//                suppression; the port list is identical in both builds.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_mux_n
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 11,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] values,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              sv_disp,
    output logic                    sv_dp,
    output logic [NUM_DIGITS-1:0]   sv_anode,
    output logic                    frame_done
);

    localparam int                      c_idx_w        = $clog2(NUM_DIGITS);
    localparam logic [c_idx_w-1:0]      c_last_idx     = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [7:0]              c_anode_off_all = ANODE_OFF(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0]   c_anode_off    = c_anode_off_all[NUM_DIGITS-1:0];

    // Refresh timing
    logic [DIV_W-1:0]          r_slot_cnt;
    logic [c_idx_w-1:0]        r_idx;
    logic                      w_slot_wrap;
    logic                      w_last_digit;
    logic                      w_frame_wrap;

    // Load path: staging holds the latest request, shadow holds what is shown
    logic                      r_pending;
    logic [4*NUM_DIGITS-1:0]   r_stage_values;
    logic [NUM_DIGITS-1:0]     r_stage_dp;
    logic [NUM_DIGITS-1:0]     r_stage_blank;
    logic [4*NUM_DIGITS-1:0]   r_shadow_values;
    logic [NUM_DIGITS-1:0]     r_shadow_dp;
    logic [NUM_DIGITS-1:0]     r_shadow_blank;
    logic                      r_frame_done;

    // Digit selection and darkness decision
    logic [3:0]                w_digit_val [NUM_DIGITS];
    logic [3:0]                w_nibble;
    logic [6:0]                w_seg;
    logic                      w_dp_sel;
    logic [NUM_DIGITS-1:0]     w_lz_supp;
    logic [BRIGHT_W-1:0]       w_duty_code;
    logic                      w_in_duty;
    logic                      w_dark;
    logic [NUM_DIGITS-1:0]     w_anode_lit;

    // Registered output stage
    logic [NUM_DIGITS-1:0]     r_anode;
    logic [6:0]                r_disp;
    logic                      r_dp;

    // Slot and frame boundaries derived from the current counters.
    always_comb begin
        w_slot_wrap  = &r_slot_cnt;
        w_last_digit = (r_idx == c_last_idx);
        w_frame_wrap = w_slot_wrap & w_last_digit;
    end

    // Prescaler and digit index: idx steps once per full slot, wraps per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + DIV_W'(1);
            if (w_slot_wrap) begin
                r_idx <= w_last_digit ? '0 : r_idx + c_idx_w'(1);
            end
        end
    end

    // Load handshake: stage requests, commit to shadow only at frame wrap.
    // A load on the wrap cycle itself bypasses staging so its data wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending       <= 1'b0;
            r_stage_values  <= '0;
            r_stage_dp      <= '0;
            r_stage_blank   <= '1;
            r_shadow_values <= '0;
            r_shadow_dp     <= '0;
            r_shadow_blank  <= '1;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (load) begin
                r_stage_values <= values;
                r_stage_dp     <= dp_in;
                r_stage_blank  <= blank;
            end
            if (w_frame_wrap) begin
                if (load) begin
                    r_shadow_values <= values;
                    r_shadow_dp     <= dp_in;
                    r_shadow_blank  <= blank;
                end else if (r_pending) begin
                    r_shadow_values <= r_stage_values;
                    r_shadow_dp     <= r_stage_dp;
                    r_shadow_blank  <= r_stage_blank;
                end
                r_frame_done <= load | r_pending;
                r_pending    <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Split the shadow value bus into per-digit nibbles.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_split
        assign w_digit_val[g] = r_shadow_values[4*g +: 4];
    end

`ifdef SEVSEG_LZ_BLANK_EN
    // Leading-zero suppression: walk down from the top digit while digits are
    // zero with no decimal point; digit 0 is always shown.
    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_lz_supp = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            v_run        = v_run & (w_digit_val[i] == 4'h0) & ~r_shadow_dp[i];
            w_lz_supp[i] = v_run;
        end
    end
`else
    // Zeros are always displayed in this build.
    assign w_lz_supp = '0;
`endif

    // Current digit content, duty window and dark decision.
    always_comb begin
        w_nibble    = w_digit_val[r_idx];
        w_dp_sel    = r_shadow_dp[r_idx];
        w_duty_code = r_slot_cnt[DIV_W-1 -: BRIGHT_W];
        w_in_duty   = (w_duty_code <= brightness);
        w_dark      = r_shadow_blank[r_idx] | w_lz_supp[r_idx] | ~w_in_duty;
    end

    // One-hot-low anode pattern for the selected digit.
    always_comb begin
        w_anode_lit = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_anode_lit[i] = (r_idx != c_idx_w'(i));
        end
    end

    sevseg_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Output register: dark digits release both anodes and cathodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode <= c_anode_off;
            r_disp  <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else if (w_dark) begin
            r_anode <= c_anode_off;
            r_disp  <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_anode_lit;
            r_disp  <= w_seg;
            r_dp    <= ~w_dp_sel;
        end
    end

    assign sv_anode   = r_anode;
    assign sv_disp    = r_disp;
    assign sv_dp      = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
